// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: redirect/stall controls from decode, hazard unit and CP0,
// the instruction-ROM port, and the F/D pipeline register outputs.
interface fetch_unit_if;
    logic        stall_F;
    logic        pc_mux_sel;
    logic [31:0] npc_in;
    logic        branch_in_d;
    logic        if_eret;
    logic        exc_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic [31:0] pc4_d;
    logic [4:0]  exc_code_d;
    logic        bd_d;

    modport master (
        input  stall_F, pc_mux_sel, npc_in, branch_in_d, if_eret, exc_req, imem_rdata,
        output imem_addr, instr_d, pc_d, pc4_d, exc_code_d, bd_d
    );

    modport slave (
        output stall_F, pc_mux_sel, npc_in, branch_in_d, if_eret, exc_req, imem_rdata,
        input  imem_addr, instr_d, pc_d, pc4_d, exc_code_d, bd_d
    );
endinterface

// File: rtl/fetch_unit.sv
// P7 MIPS fetch stage: PC register, redirect priority and F/D register.
// Define FETCH_ADEL_EN to tag misaligned / out-of-range fetches with AdEL (code 4).
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_4180,
    parameter logic [31:0] IMEM_LO    = 32'h0000_3000,
    parameter logic [31:0] IMEM_HI    = 32'h0000_4FFC
) (
    input logic          clk,
    input logic          reset,
    fetch_unit_if.master bus
);
`ifdef FETCH_ADEL_EN
    localparam bit ADEL_EN = 1'b1;
`else
    localparam bit ADEL_EN = 1'b0;
`endif

    logic [31:0] pc;
    logic [31:0] pc4;
    logic        adel;
    logic [31:0] instr_q;
    logic [31:0] pc_q;
    logic [31:0] pc4_q;
    logic [4:0]  exc_q;
    logic        bd_q;

    assign pc4  = pc + 32'd4;
    // With checking disabled this folds to constant 0, so exc_code_d is tied low.
    assign adel = ADEL_EN && ((pc[1:0] != 2'b00) || (pc < IMEM_LO) || (pc > IMEM_HI));

    assign bus.imem_addr  = pc;
    assign bus.instr_d    = instr_q;
    assign bus.pc_d       = pc_q;
    assign bus.pc4_d      = pc4_q;
    assign bus.exc_code_d = exc_q;
    assign bus.bd_d       = bd_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc      <= RESET_PC;
            instr_q <= 32'h0;
            pc_q    <= 32'h0;
            pc4_q   <= 32'h0;
            exc_q   <= 5'd0;
            bd_q    <= 1'b0;
        end else if (bus.exc_req) begin
            pc      <= EXC_VECTOR;
            instr_q <= 32'h0;
            pc_q    <= pc;
            pc4_q   <= pc4;
            exc_q   <= 5'd0;
            bd_q    <= 1'b0;
        end else if (bus.stall_F) begin
            // Hold everything; decode re-issues any redirect once the stall drops.
        end else if (bus.if_eret) begin
            pc      <= bus.npc_in;
            instr_q <= 32'h0;
            pc_q    <= pc;
            pc4_q   <= pc4;
            exc_q   <= 5'd0;
            bd_q    <= 1'b0;
        end else begin
            pc      <= bus.pc_mux_sel ? bus.npc_in : pc4;
            instr_q <= adel ? 32'h0 : bus.imem_rdata;
            pc_q    <= pc;
            pc4_q   <= pc4;
            exc_q   <= adel ? 5'd4 : 5'd0;
            bd_q    <= bus.branch_in_d;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, branch, stall, ERET, exception, AdEL, wrap.
module tb_fetch_unit;
    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    fetch_unit_if bus ();

    fetch_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    // ROM word at 0x3000 is 0x3408_0001, each following word increments by one.
    function automatic logic [31:0] rom(input logic [31:0] a);
        return 32'h3408_0000 + ((a - 32'h3000) >> 2) + 32'd1;
    endfunction

    assign bus.imem_rdata = rom(bus.imem_addr);

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        bus.stall_F = 0; bus.pc_mux_sel = 0; bus.npc_in = 32'h0;
        bus.branch_in_d = 0; bus.if_eret = 0; bus.exc_req = 0;
    endtask

    task automatic test_reset;
        idle();
        reset = 0;
        #12;
        checks++;
        if (bus.imem_addr !== 32'h3000) begin
            errors++; $display("FAIL reset_addr got=%h exp=%h", bus.imem_addr, 32'h3000);
        end
        checks++;
        if ({bus.instr_d, bus.pc_d, bus.pc4_d, bus.exc_code_d, bus.bd_d} !== 102'h0) begin
            errors++; $display("FAIL reset_fd instr=%h pc=%h pc4=%h exc=%0d bd=%b exp all zero",
                               bus.instr_d, bus.pc_d, bus.pc4_d, bus.exc_code_d, bus.bd_d);
        end
        @(negedge clk);
        reset = 1;
        step();
        checks++;
        if ({bus.instr_d, bus.pc_d, bus.pc4_d} !== {32'h3408_0001, 32'h3000, 32'h3004}) begin
            errors++; $display("FAIL first_fetch instr=%h pc=%h pc4=%h exp 34080001/3000/3004",
                               bus.instr_d, bus.pc_d, bus.pc4_d);
        end
        checks++;
        if (bus.imem_addr !== 32'h3004) begin
            errors++; $display("FAIL first_advance got=%h exp=%h", bus.imem_addr, 32'h3004);
        end
    endtask

    task automatic test_branch;
        bus.pc_mux_sel = 1; bus.npc_in = 32'h3010; bus.branch_in_d = 1;
        step();
        idle();
        checks++;
        if ({bus.instr_d, bus.pc_d, bus.bd_d} !== {32'h3408_0002, 32'h3004, 1'b1}) begin
            errors++; $display("FAIL branch_slot instr=%h pc=%h bd=%b exp 34080002/3004/1",
                               bus.instr_d, bus.pc_d, bus.bd_d);
        end
        checks++;
        if (bus.imem_addr !== 32'h3010) begin
            errors++; $display("FAIL branch_target got=%h exp=%h", bus.imem_addr, 32'h3010);
        end
        step();
        checks++;
        if ({bus.instr_d, bus.pc_d, bus.bd_d, bus.imem_addr} !== {32'h3408_0005, 32'h3010, 1'b0, 32'h3014}) begin
            errors++; $display("FAIL branch_land instr=%h pc=%h bd=%b addr=%h exp 34080005/3010/0/3014",
                               bus.instr_d, bus.pc_d, bus.bd_d, bus.imem_addr);
        end
    endtask

    task automatic test_stall;
        bus.pc_mux_sel = 1; bus.npc_in = 32'h3008;
        step();
        idle();
        bus.stall_F = 1;
        for (int i = 0; i < 3; i++) begin
            bus.pc_mux_sel = (i == 1); bus.npc_in = 32'h3030;
            step();
            checks++;
            if ({bus.imem_addr, bus.instr_d, bus.pc_d} !== {32'h3008, 32'h3408_0006, 32'h3014}) begin
                errors++; $display("FAIL stall_hold[%0d] addr=%h instr=%h pc=%h exp 3008/34080006/3014",
                                   i, bus.imem_addr, bus.instr_d, bus.pc_d);
            end
        end
        idle();
        step();
        checks++;
        if ({bus.pc_d, bus.imem_addr} !== {32'h3008, 32'h300c}) begin
            errors++; $display("FAIL stall_release pc=%h addr=%h exp 3008/300c", bus.pc_d, bus.imem_addr);
        end
    endtask

    task automatic test_eret;
        bus.pc_mux_sel = 1; bus.npc_in = 32'h3040;
        step();
        bus.if_eret = 1; bus.npc_in = 32'h3020;
        step();
        idle();
        checks++;
        if ({bus.instr_d, bus.pc_d, bus.bd_d, bus.imem_addr} !== {32'h0, 32'h3040, 1'b0, 32'h3020}) begin
            errors++; $display("FAIL eret_kill instr=%h pc=%h bd=%b addr=%h exp 0/3040/0/3020",
                               bus.instr_d, bus.pc_d, bus.bd_d, bus.imem_addr);
        end
        step();
        checks++;
        if ({bus.instr_d, bus.pc_d} !== {32'h3408_0009, 32'h3020}) begin
            errors++; $display("FAIL eret_return instr=%h pc=%h exp 34080009/3020", bus.instr_d, bus.pc_d);
        end
    endtask

    task automatic test_exception;
        bus.exc_req = 1; bus.stall_F = 1; bus.if_eret = 1; bus.pc_mux_sel = 1;
        bus.npc_in = 32'h3050; bus.branch_in_d = 1;
        step();
        idle();
        checks++;
        if (bus.imem_addr !== 32'h4180) begin
            errors++; $display("FAIL exc_vector got=%h exp=%h", bus.imem_addr, 32'h4180);
        end
        checks++;
        if ({bus.instr_d, bus.pc_d, bus.pc4_d, bus.bd_d, bus.exc_code_d} !== {32'h0, 32'h3024, 32'h3028, 1'b0, 5'd0}) begin
            errors++; $display("FAIL exc_bubble instr=%h pc=%h pc4=%h bd=%b exc=%0d exp 0/3024/3028/0/0",
                               bus.instr_d, bus.pc_d, bus.pc4_d, bus.bd_d, bus.exc_code_d);
        end
        step();
        checks++;
        if ({bus.instr_d, bus.pc_d} !== {32'h3408_0461, 32'h4180}) begin
            errors++; $display("FAIL exc_handler instr=%h pc=%h exp 34080461/4180", bus.instr_d, bus.pc_d);
        end
    endtask

    task automatic test_adel;
        logic [31:0] exp_instr;
        logic [4:0]  exp_code;
`ifdef FETCH_ADEL_EN
        exp_instr = 32'h0; exp_code = 5'd4;
`else
        exp_instr = 32'h3408_0001; exp_code = 5'd0;
`endif
        bus.pc_mux_sel = 1; bus.npc_in = 32'h3002;
        step();
        idle();
        step();
        checks++;
        if ({bus.exc_code_d, bus.instr_d, bus.pc_d} !== {exp_code, exp_instr, 32'h3002}) begin
            errors++; $display("FAIL adel_misalign exc=%0d instr=%h pc=%h exp %0d/%h/3002",
                               bus.exc_code_d, bus.instr_d, bus.pc_d, exp_code, exp_instr);
        end
        checks++;
        if (bus.imem_addr !== 32'h3006) begin
            errors++; $display("FAIL adel_advance got=%h exp=%h", bus.imem_addr, 32'h3006);
        end
        // Top legal word, then the first address beyond it.
        bus.pc_mux_sel = 1; bus.npc_in = 32'h4FFC;
        step();
        idle();
        step();
        checks++;
        if ({bus.exc_code_d, bus.instr_d} !== {5'd0, 32'h3408_0800}) begin
            errors++; $display("FAIL adel_hi_legal exc=%0d instr=%h exp 0/34080800", bus.exc_code_d, bus.instr_d);
        end
        step();
`ifdef FETCH_ADEL_EN
        exp_instr = 32'h0;
`else
        exp_instr = 32'h3408_0801;
`endif
        checks++;
        if ({bus.exc_code_d, bus.instr_d, bus.pc_d} !== {exp_code, exp_instr, 32'h5000}) begin
            errors++; $display("FAIL adel_hi_over exc=%0d instr=%h pc=%h exp %0d/%h/5000",
                               bus.exc_code_d, bus.instr_d, bus.pc_d, exp_code, exp_instr);
        end
    endtask

    task automatic test_wrap;
        bus.pc_mux_sel = 1; bus.npc_in = 32'hFFFF_FFFC;
        step();
        idle();
        step();
        checks++;
        if ({bus.pc_d, bus.pc4_d, bus.imem_addr} !== {32'hFFFF_FFFC, 32'h0, 32'h0}) begin
            errors++; $display("FAIL pc_wrap pc=%h pc4=%h addr=%h exp fffffffc/0/0",
                               bus.pc_d, bus.pc4_d, bus.imem_addr);
        end
    endtask

    task automatic test_reset_mid;
        bus.stall_F = 1; bus.pc_mux_sel = 1; bus.npc_in = 32'h3070;
        #2;
        reset = 0;
        #1;
        checks++;
        if ({bus.imem_addr, bus.instr_d, bus.pc_d} !== {32'h3000, 32'h0, 32'h0}) begin
            errors++; $display("FAIL reset_async addr=%h instr=%h pc=%h exp 3000/0/0",
                               bus.imem_addr, bus.instr_d, bus.pc_d);
        end
        idle();
        @(negedge clk);
        reset = 1;
        step();
        checks++;
        if ({bus.pc_d, bus.instr_d, bus.imem_addr} !== {32'h3000, 32'h3408_0001, 32'h3004}) begin
            errors++; $display("FAIL reset_restart pc=%h instr=%h addr=%h exp 3000/34080001/3004",
                               bus.pc_d, bus.instr_d, bus.imem_addr);
        end
    endtask

    initial begin
        test_reset();
        test_branch();
        test_stall();
        test_eret();
        test_exception();
        test_adel();
        test_wrap();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
